// File: rtl/audio_gain_ctrl_pkg.sv
// Shared types, default parameters and arithmetic helpers for the audio gain stage.
package audio_pkg;

  localparam int DEF_DATA_W          = 16;
  localparam int DEF_NUM_CH          = 2;
  localparam int DEF_GAIN_W          = 8;
  localparam int DEF_GAIN_FRAC       = 4;
  localparam int DEF_RAMP_STEP       = 1;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } btn_state_t;

  // k=0 mutes, otherwise 2^(k-1) in the gain's fixed-point format
  function automatic logic [31:0] step_to_gain(input logic [31:0] k);
    logic [31:0] g;
    if (k == 32'd0) begin
      g = 32'd0;
    end else begin
      g = 32'd1 << (k - 32'd1);
    end
    return g;
  endfunction

  // Returns {clip, value}: product shifted right arithmetically, then clamped to data_w signed
  function automatic logic [64:0] sat_clip(input logic signed [63:0] product,
                                           input int frac, input int data_w);
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic [64:0]        r;
    sh = product >>> frac;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (sh > hi) begin
      r = {1'b1, hi};
    end else if (sh < lo) begin
      r = {1'b1, lo};
    end else begin
      r = {1'b0, sh};
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_gain_ctrl_if.sv
// Sample stream bus between the codec receive path, the gain stage and the DAC path.
interface audio_gain_ctrl_if #(
  parameter int DATA_W = audio_pkg::DEF_DATA_W,
  parameter int NUM_CH = audio_pkg::DEF_NUM_CH
);
  logic                     sample_valid;
  logic [NUM_CH*DATA_W-1:0] sample_in;
  logic [NUM_CH*DATA_W-1:0] sample_out;
  logic                     out_valid;
  logic [NUM_CH-1:0]        clip;

  modport master (output sample_valid, sample_in, input sample_out, out_valid, clip);
  modport slave  (input sample_valid, sample_in, output sample_out, out_valid, clip);
endinterface

// File: rtl/audio_gain_ctrl_debounce.sv
// Synchronises the volume buttons and emits one step pulse per stable press (no auto-repeat).
module audio_button_debounce
  import audio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic CLOCK_50,
  input  logic AUD_DACLRCK,
  input  logic vol_up,
  input  logic vol_down,
  output logic step_up,
  output logic step_down
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync1_r;
  logic [1:0]       pair_r;
  logic [1:0]       last_r;
  logic [CNT_W-1:0] cnt_r;
  btn_state_t       state_r;
  logic             step_up_r;
  logic             step_down_r;

  // Two-flop synchroniser, bit 0 = up, bit 1 = down
  always_ff @(posedge CLOCK_50 or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      sync1_r <= 2'b00;
      pair_r  <= 2'b00;
    end else begin
      sync1_r <= {vol_down, vol_up};
      pair_r  <= sync1_r;
    end
  end

  // Press/release debounce FSM with registered step pulses
  always_ff @(posedge CLOCK_50 or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      last_r      <= 2'b00;
      step_up_r   <= 1'b0;
      step_down_r <= 1'b0;
    end else begin
      step_up_r   <= 1'b0;
      step_down_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pair_r != 2'b00) begin
            cnt_r   <= CNT_LOAD;
            last_r  <= pair_r;
            state_r <= PRESS_DB;
          end else begin
            state_r <= IDLE;
          end
        end
        PRESS_DB: begin
          if (pair_r != last_r) begin
            cnt_r   <= CNT_LOAD;
            last_r  <= pair_r;
            state_r <= (pair_r == 2'b00) ? IDLE : PRESS_DB;
          end else if (cnt_r == {CNT_W{1'b0}}) begin
            // Both buttons together are deliberately a no-op
            step_up_r   <= (pair_r == 2'b01);
            step_down_r <= (pair_r == 2'b10);
            state_r     <= HELD;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        HELD: begin
          if (pair_r == 2'b00) begin
            cnt_r   <= CNT_LOAD;
            state_r <= REL_DB;
          end else begin
            state_r <= HELD;
          end
        end
        REL_DB: begin
          if (pair_r != 2'b00) begin
            state_r <= HELD;
          end else if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign step_up   = step_up_r;
  assign step_down = step_down_r;

endmodule

// File: rtl/audio_gain_ctrl.sv
// Multi-channel volume stage: log gain steps from buttons, per-sample gain ramp,
// two-stage saturating multiply with an equal-latency bypass.
module audio_gain_ctrl
  import audio_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int GAIN_W          = DEF_GAIN_W,
  parameter int GAIN_FRAC       = DEF_GAIN_FRAC,
  parameter int RAMP_STEP       = DEF_RAMP_STEP,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                        CLOCK_50,
  input  logic                        AUD_DACLRCK,
  input  logic                        dsp_enable,
  input  logic                        vol_up,
  input  logic                        vol_down,
  audio_gain_ctrl_if.slave            bus,
  output logic [$clog2(GAIN_W+1)-1:0] gain_idx
);
  localparam int IDX_W  = $clog2(GAIN_W + 1);
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam logic [IDX_W-1:0]  RESET_IDX = IDX_W'(GAIN_FRAC + 1);
  localparam logic [IDX_W-1:0]  MAX_IDX   = IDX_W'(GAIN_W);
  localparam logic [GAIN_W-1:0] UNITY     = GAIN_W'(1 << GAIN_FRAC);
  localparam logic [GAIN_W-1:0] RAMP_L    = GAIN_W'(RAMP_STEP);

  logic                     step_up_s;
  logic                     step_down_s;
  logic [IDX_W-1:0]         k_r;
  logic [GAIN_W-1:0]        target_gain_s;
  logic [GAIN_W-1:0]        cur_gain_r;
  logic [GAIN_W-1:0]        gain_diff_s;
  logic [GAIN_W-1:0]        gain_step_s;
  logic [GAIN_W-1:0]        next_gain_s;
  logic                     v1_r;
  logic                     en1_r;
  logic                     out_valid_r;
  logic signed [PROD_W-1:0] prod_s [NUM_CH];
  logic signed [PROD_W-1:0] prod_r [NUM_CH];
  logic [DATA_W-1:0]        byp_r [NUM_CH];
  logic [DATA_W-1:0]        sat_val_s [NUM_CH];
  logic [NUM_CH-1:0]        sat_clip_s;
  logic [NUM_CH-1:0]        clip_r;
  logic [NUM_CH*DATA_W-1:0] out_r;

  audio_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .CLOCK_50    (CLOCK_50),
    .AUD_DACLRCK (AUD_DACLRCK),
    .vol_up      (vol_up),
    .vol_down    (vol_down),
    .step_up     (step_up_s),
    .step_down   (step_down_s)
  );

  // Step index, clamped to 0..GAIN_W
  always_ff @(posedge CLOCK_50 or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      k_r <= RESET_IDX;
    end else if (step_up_s && (k_r != MAX_IDX)) begin
      k_r <= k_r + IDX_W'(1);
    end else if (step_down_s && (k_r != {IDX_W{1'b0}})) begin
      k_r <= k_r - IDX_W'(1);
    end else begin
      k_r <= k_r;
    end
  end

  assign target_gain_s = GAIN_W'(step_to_gain(32'(k_r)));

  // Next applied gain: move toward target by at most RAMP_STEP
  always_comb begin
    gain_diff_s = {GAIN_W{1'b0}};
    next_gain_s = cur_gain_r;
    if (cur_gain_r < target_gain_s) begin
      gain_diff_s = target_gain_s - cur_gain_r;
    end else begin
      gain_diff_s = cur_gain_r - target_gain_s;
    end
    gain_step_s = (gain_diff_s > RAMP_L) ? RAMP_L : gain_diff_s;
    if (cur_gain_r < target_gain_s) begin
      next_gain_s = cur_gain_r + gain_step_s;
    end else begin
      next_gain_s = cur_gain_r - gain_step_s;
    end
  end

  // Applied gain advances once per accepted sample, after that sample's multiply
  always_ff @(posedge CLOCK_50 or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      cur_gain_r <= UNITY;
    end else if (bus.sample_valid) begin
      cur_gain_r <= next_gain_s;
    end else begin
      cur_gain_r <= cur_gain_r;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic signed [DATA_W-1:0] smp_s;
    logic signed [63:0]       prod_ext_s;
    assign smp_s      = bus.sample_in[ch*DATA_W +: DATA_W];
    assign prod_s[ch] = $signed({{(PROD_W-DATA_W){smp_s[DATA_W-1]}}, smp_s})
                      * $signed({{(PROD_W-GAIN_W){1'b0}}, cur_gain_r});
    assign prod_ext_s     = {{(64-PROD_W){prod_r[ch][PROD_W-1]}}, prod_r[ch]};
    assign sat_val_s[ch]  = DATA_W'(sat_clip(prod_ext_s, GAIN_FRAC, DATA_W));
    assign sat_clip_s[ch] = 1'(sat_clip(prod_ext_s, GAIN_FRAC, DATA_W) >> 7'd64);
  end

  // Stage 1: products plus raw samples for bypass
  always_ff @(posedge CLOCK_50 or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      v1_r  <= 1'b0;
      en1_r <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        prod_r[i] <= {PROD_W{1'b0}};
        byp_r[i]  <= {DATA_W{1'b0}};
      end
    end else begin
      v1_r <= bus.sample_valid;
      if (bus.sample_valid) begin
        en1_r <= dsp_enable;
        for (int i = 0; i < NUM_CH; i++) begin
          prod_r[i] <= prod_s[i];
          byp_r[i]  <= bus.sample_in[i*DATA_W +: DATA_W];
        end
      end else begin
        en1_r <= en1_r;
      end
    end
  end

  // Stage 2: shift/saturate or bypass; outputs hold between valids
  always_ff @(posedge CLOCK_50 or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      out_valid_r <= 1'b0;
      out_r       <= {(NUM_CH*DATA_W){1'b0}};
      clip_r      <= {NUM_CH{1'b0}};
    end else begin
      out_valid_r <= v1_r;
      if (v1_r) begin
        for (int i = 0; i < NUM_CH; i++) begin
          out_r[i*DATA_W +: DATA_W] <= en1_r ? sat_val_s[i] : byp_r[i];
        end
        clip_r <= en1_r ? sat_clip_s : {NUM_CH{1'b0}};
      end else begin
        clip_r <= clip_r;
      end
    end
  end

  assign bus.sample_out = out_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.clip       = clip_r;
  assign gain_idx       = k_r;

endmodule

// File: tb/tb_audio_gain_ctrl.sv
// Directed bench for audio_gain_ctrl with short debounce and a fast ramp.
module tb_audio_gain_ctrl;
  logic       CLOCK_50 = 1'b0;
  logic       AUD_DACLRCK;
  logic       dsp_enable;
  logic       vol_up;
  logic       vol_down;
  logic [3:0] gain_idx;
  int         tests = 0;
  int         fails = 0;

  audio_gain_ctrl_if #(.DATA_W(16), .NUM_CH(2)) bus ();

  audio_gain_ctrl #(
    .DATA_W(16), .NUM_CH(2), .GAIN_W(8), .GAIN_FRAC(4),
    .RAMP_STEP(4), .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .AUD_DACLRCK (AUD_DACLRCK),
    .dsp_enable  (dsp_enable),
    .vol_up      (vol_up),
    .vol_down    (vol_down),
    .bus         (bus),
    .gain_idx    (gain_idx)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // One strobe; returns at the falling edge where its output is valid
  task automatic send(input logic [15:0] l, input logic [15:0] r);
    @(negedge CLOCK_50);
    bus.sample_valid = 1'b1;
    bus.sample_in    = {r, l};
    @(negedge CLOCK_50);
    bus.sample_valid = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic press(input logic up, input logic dn);
    @(negedge CLOCK_50);
    vol_up   = up;
    vol_down = dn;
    repeat (10) @(negedge CLOCK_50);
    vol_up   = 1'b0;
    vol_down = 1'b0;
    repeat (10) @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    AUD_DACLRCK = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    AUD_DACLRCK = 1'b0;
  endtask

  task automatic test_reset();
    AUD_DACLRCK      = 1'b1;
    dsp_enable       = 1'b1;
    vol_up           = 1'b0;
    vol_down         = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = 32'h0;
    repeat (3) @(negedge CLOCK_50);
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    tests++; if (bus.sample_out !== 32'h0) begin fails++; $display("FAIL rst_out: got %h want 00000000", bus.sample_out); end
    tests++; if (bus.clip !== 2'b00) begin fails++; $display("FAIL rst_clip: got %b want 00", bus.clip); end
    tests++; if (gain_idx !== 4'd5) begin fails++; $display("FAIL rst_idx: got %0d want 5", gain_idx); end
    AUD_DACLRCK = 1'b0;
    send(16'h1000, 16'hF000);
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL pass_valid: got %b want 1", bus.out_valid); end
    tests++; if (bus.sample_out !== 32'hF000_1000) begin fails++; $display("FAIL pass_out: got %h want f0001000", bus.sample_out); end
    tests++; if (bus.clip !== 2'b00) begin fails++; $display("FAIL pass_clip: got %b want 00", bus.clip); end
    tests++; if (gain_idx !== 4'd5) begin fails++; $display("FAIL pass_idx: got %0d want 5", gain_idx); end
    @(negedge CLOCK_50);
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL pass_valid_drop: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_debounce_sat();
    repeat (3) press(1'b1, 1'b0);
    tests++; if (gain_idx !== 4'd8) begin fails++; $display("FAIL up3_idx: got %0d want 8", gain_idx); end
    repeat (28) send(16'h0000, 16'h0000);
    send(16'h0010, 16'hFFF0);
    tests++; if (bus.sample_out !== 32'hFF80_0080) begin fails++; $display("FAIL gain128_out: got %h want ff800080", bus.sample_out); end
    tests++; if (bus.clip !== 2'b00) begin fails++; $display("FAIL gain128_clip: got %b want 00", bus.clip); end
    send(16'h1000, 16'hB1E0);
    tests++; if (bus.sample_out !== 32'h8000_7FFF) begin fails++; $display("FAIL sat_out: got %h want 80007fff", bus.sample_out); end
    tests++; if (bus.clip !== 2'b11) begin fails++; $display("FAIL sat_clip: got %b want 11", bus.clip); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      vol_down = ~vol_down;
      @(negedge CLOCK_50);
    end
    vol_down = 1'b0;
    repeat (12) @(negedge CLOCK_50);
    tests++; if (gain_idx !== 4'd8) begin fails++; $display("FAIL bounce_idx: got %0d want 8", gain_idx); end
    press(1'b0, 1'b1);
    tests++; if (gain_idx !== 4'd7) begin fails++; $display("FAIL down1_idx: got %0d want 7", gain_idx); end
    press(1'b1, 1'b1);
    tests++; if (gain_idx !== 4'd7) begin fails++; $display("FAIL both_idx: got %0d want 7", gain_idx); end
  endtask

  task automatic test_ramp();
    logic [15:0] exp_r [7] = '{16'h0100, 16'h0140, 16'h0180, 16'h01C0, 16'h0200, 16'h0200, 16'h0200};
    do_reset();
    press(1'b1, 1'b0);
    tests++; if (gain_idx !== 4'd6) begin fails++; $display("FAIL ramp_idx: got %0d want 6", gain_idx); end
    for (int i = 0; i < 7; i++) begin
      send(16'h0100, 16'h0100);
      tests++;
      if (bus.sample_out !== {exp_r[i], exp_r[i]}) begin
        fails++; $display("FAIL ramp_out[%0d]: got %h want %h", i, bus.sample_out, {exp_r[i], exp_r[i]});
      end
    end
  endtask

  task automatic test_limits();
    do_reset();
    repeat (6) press(1'b0, 1'b1);
    tests++; if (gain_idx !== 4'd0) begin fails++; $display("FAIL min_idx: got %0d want 0", gain_idx); end
    repeat (5) send(16'h1000, 16'h1000);
    send(16'h1000, 16'hF000);
    tests++; if (bus.sample_out !== 32'h0) begin fails++; $display("FAIL mute_out: got %h want 00000000", bus.sample_out); end
    tests++; if (bus.clip !== 2'b00) begin fails++; $display("FAIL mute_clip: got %b want 00", bus.clip); end
    repeat (9) press(1'b1, 1'b0);
    tests++; if (gain_idx !== 4'd8) begin fails++; $display("FAIL max_idx: got %0d want 8", gain_idx); end
  endtask

  task automatic test_bypass_reset();
    int seen;
    dsp_enable = 1'b0;
    send(16'h7000, 16'h7000);
    tests++; if (bus.sample_out !== 32'h7000_7000) begin fails++; $display("FAIL byp_out: got %h want 70007000", bus.sample_out); end
    tests++; if (bus.clip !== 2'b00) begin fails++; $display("FAIL byp_clip: got %b want 00", bus.clip); end
    dsp_enable = 1'b1;
    @(negedge CLOCK_50);
    bus.sample_valid = 1'b1;
    bus.sample_in    = 32'h1234_1234;
    @(negedge CLOCK_50);
    bus.sample_valid = 1'b0;
    AUD_DACLRCK      = 1'b1;
    seen = 0;
    @(negedge CLOCK_50);
    if (bus.out_valid === 1'b1) seen++;
    AUD_DACLRCK = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50);
      if (bus.out_valid === 1'b1) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL flush_valid: got %0d valids want 0", seen); end
    tests++; if (gain_idx !== 4'd5) begin fails++; $display("FAIL rst_idx2: got %0d want 5", gain_idx); end
  endtask

  task automatic test_back_to_back();
    @(negedge CLOCK_50);
    bus.sample_valid = 1'b1;
    bus.sample_in    = {16'h8000, 16'h1234};
    @(negedge CLOCK_50);
    bus.sample_in    = {16'h0001, 16'h7FFF};
    @(negedge CLOCK_50);
    bus.sample_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL b2b_v0: got %b want 1", bus.out_valid); end
    tests++; if (bus.sample_out !== 32'h8000_1234) begin fails++; $display("FAIL b2b_out0: got %h want 80001234", bus.sample_out); end
    @(negedge CLOCK_50);
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL b2b_v1: got %b want 1", bus.out_valid); end
    tests++; if (bus.sample_out !== 32'h0001_7FFF) begin fails++; $display("FAIL b2b_out1: got %h want 00017fff", bus.sample_out); end
    tests++; if (bus.clip !== 2'b00) begin fails++; $display("FAIL b2b_clip: got %b want 00", bus.clip); end
    @(negedge CLOCK_50);
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_v2: got %b want 0", bus.out_valid); end
    tests++; if (bus.sample_out !== 32'h0001_7FFF) begin fails++; $display("FAIL b2b_hold: got %h want 00017fff", bus.sample_out); end
  endtask

  initial begin
    test_reset();
    test_debounce_sat();
    test_bounce();
    test_ramp();
    test_limits();
    test_bypass_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/audio_gain_ctrl.md
# audio_gain_ctrl

Parametrised multi-channel digital volume stage between the codec receive path and the DAC transmit path, running entirely in the CLOCK_50 domain. It debounces the volume buttons, steps a logarithmic gain target, ramps the applied linear gain toward that target once per sample to avoid zipper noise, and multiplies every channel with full saturation. When `dsp_enable` is low the samples pass through with the same pipeline latency.

## Interface
- `DATA_W`, 16: signed sample width per channel.
- `NUM_CH`, 2: channel count, with channel 0 in the LSBs of the packed buses.
- `GAIN_W`, 8: unsigned gain register width.
- `GAIN_FRAC`, 4: fractional bits of the gain, so unity = 2^GAIN_FRAC.
- `RAMP_STEP`, 1: maximum change in applied gain per accepted sample.
- `DEBOUNCE_CYCLES`, 500000: number of stable CLOCK_50 cycles required on the buttons.

- `CLOCK_50`, input, 1: system clock, all logic runs on its rising edge.
- `AUD_DACLRCK`, input, 1: reset, asynchronous, active-high.
- `dsp_enable`, input, 1: 1 applies gain, 0 selects bypass.
- `vol_up`, `vol_down`, input, 1 each: raw asynchronous buttons, active-high.
- `sample_valid`, input, 1: single-cycle strobe qualifying `sample_in`; back-to-back strobes are legal.
- `sample_in`, input, NUM_CH*DATA_W: packed signed samples.
- `sample_out`, output, NUM_CH*DATA_W: packed processed samples.
- `out_valid`, output, 1: qualifies `sample_out` and `clip`.
- `clip`, output, NUM_CH: per-channel saturation occurred on this output.
- `gain_idx`, output, $clog2(GAIN_W+1): current target step index, intended for display.

## Operation
- **Gain steps.** Step index k covers 0..GAIN_W.
  - k=0 gives gain 0 (mute).
  - k≥1 gives gain 2^(k-1) in Q(GAIN_W-GAIN_FRAC).GAIN_FRAC.
  - Defaults: k=5 is unity (16), k=8 is the maximum, 128 = 8x.
- **Button synchronisation.** Each button passes through a 2-FF synchroniser. The synchronised pair feeds one FSM:
  - IDLE: pair==00 stays in IDLE; any nonzero value loads the counter and moves to PRESS_DB.
  - PRESS_DB: any change in the pair reloads the counter. If the pair returns to 00, go to IDLE. When the counter expires, apply one step if exactly one button is set; if both are set, make no change. Then go to HELD.
  - HELD: pair==00 loads the counter and moves to REL_DB. There is no auto-repeat.
  - REL_DB: any nonzero value returns to HELD. When the counter expires with the pair still 00, go to IDLE.
- **Step limits.** A step up at k=GAIN_W has no effect. A step down at k=0 has no effect.
- **Gain ramp.** `target_gain` is derived from k. On every accepted `sample_valid`, `cur_gain` moves toward `target_gain` by min(RAMP_STEP, |difference|). The multiply for that sample uses the value of `cur_gain` before this update.
- **Arithmetic.**
  - Form the product of the signed DATA_W sample and the zero-extended gain, treated as signed GAIN_W+1.
  - The product is DATA_W+GAIN_W+1 bits wide.
  - Apply an arithmetic shift right by GAIN_FRAC, which truncates toward -inf.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Set `clip[ch]` when saturation happens.
- **Bypass.** When `dsp_enable`=0, the stage-2 output equals the input sample and `clip`=0. The ramp and the FSM keep running in bypass.
- `dsp_enable` is sampled in the `sample_valid` cycle and carried down the pipeline with the sample.

## Timing
- **Latency.** The sample is registered into stage 1 (the products) on the `sample_valid` edge. Stage 2 (shift and saturate) and `out_valid` follow one edge later. `out_valid` is therefore high in cycle N+2 for a strobe in cycle N.
- **Throughput.** One sample set per cycle.
- **Outputs between valids.** `sample_out` holds its last value. `clip` is meaningful only while `out_valid`=1.
- **Step timing.** A gain step takes effect on `gain_idx` one cycle after the debounce counter expires. It affects `cur_gain` from the next `sample_valid` onward.
- **Reset values.** `out_valid`=0, `sample_out`=0, `clip`=0, k=GAIN_FRAC+1, `target_gain`=`cur_gain`=unity, FSM=IDLE, counter=0, synchronisers=0.
- **Reset mid-operation.** Samples in flight are discarded and no `out_valid` is produced for them.

## Structure
- **Package `audio_pkg`:**
  - `btn_state_t` enum: IDLE, PRESS_DB, HELD, REL_DB.
  - Function `step_to_gain(k)`.
  - Function `sat_clip(product)`.
  - Default localparams for the parameters.
- **Sub-module `audio_button_debounce`:** contains the synchroniser, counter and FSM. It outputs single-cycle `step_up` and `step_down` pulses.
- **Top `audio_gain_ctrl`:** contains the step register, the ramp and the per-channel generate loop for the 2-stage datapath.

## Test plan
All scenarios use the bench parameters DEBOUNCE_CYCLES=4 and RAMP_STEP=4, with the default widths.
- **Reset passthrough.** Release reset, `dsp_enable`=1, send L=0x1000, R=0xF000 -> two cycles later `out_valid`=1 with outputs 0x1000 and 0xF000, `clip`=00, `gain_idx`=5.
- **Debounce and saturation.** Apply three clean `vol_up` presses, each held 10 cycles and released for 10 -> `gain_idx`=8. After 28 samples `cur_gain`=128. Then input 0x1000 -> output 0x7FFF with `clip`=1, and input 0xB1E0 (-20000) -> 0x8000 with `clip`=1.
- **Bounce rejection.** Toggle `vol_down` every 2 cycles for 20 cycles, then release -> `gain_idx` unchanged. Then press once stably -> `gain_idx` drops by exactly 1. Pressing both buttons together -> no change.
- **Ramp.** From k=5, step up to k=6 and feed constant input 0x0100 -> successive outputs 0x0100, 0x0140, 0x0180, 0x01C0, 0x0200, after which the output stays at 0x0200.
- **Limits.** Six `vol_down` presses from k=5 -> `gain_idx`=0, and once ramped the output is 0. Nine `vol_up` presses from k=0 -> `gain_idx`=8.
- **Bypass and reset.** With `dsp_enable`=0 at k=8, input 0x7000 -> output 0x7000 with `clip`=0. Assert reset one cycle after a `sample_valid` -> no `out_valid` appears and `gain_idx` returns to 5.
